// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer.
// Holds the FSM state type, privilege encodings and cause codes.
package trap_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        ENTER = 2'd1,
        EXIT  = 2'd2
    } state_t;

    localparam logic PRIV_M = 1'b1;
    localparam logic PRIV_U = 1'b0;

    localparam int CAUSE_ILLEGAL = 2;
    localparam int CAUSE_ECALL_U = 8;
    localparam int CAUSE_ECALL_M = 11;
    localparam int CAUSE_MEI     = 11;

endpackage

// File: rtl/trap_controller.sv
// Trap/mret sequencer driving en/sel of the fetch PC-source mux.
// Optional macro TRAP_INTERRUPT_EN enables external interrupt entry.
module trap_controller
    import trap_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 4
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic [XLEN-1:0]    I_pc,
    input  logic               I_exc,
    input  logic [CAUSE_W-1:0] I_exc_cause,
    input  logic               I_mret,
    input  logic               I_ready,
    input  logic               I_irq,
    output logic               O_en,
    output logic               O_sel,
    output logic               O_flush,
    output logic               O_busy,
    output logic [XLEN-1:0]    O_mepc,
    output logic [XLEN-1:0]    O_mcause,
    output logic               O_priv,
    output logic               O_mie
);

    state_t state;
    logic   mpie;
    logic   mpp;

    logic               illegal_mret;
    logic               irq_take;
    logic               take_trap;
    logic               take_mret;
    logic               irq_flag;
    logic [CAUSE_W-1:0] trap_cause;
    logic [XLEN-1:0]    mcause_next;

`ifdef TRAP_INTERRUPT_EN
    assign irq_take = I_irq && O_mie && !I_exc;
`else
    logic unused_irq;
    assign unused_irq = I_irq;
    assign irq_take   = 1'b0;
`endif

    // Decode the request priority: exception > interrupt > illegal mret > mret
    always_comb begin
        illegal_mret = I_mret && (O_priv == PRIV_U);
        take_trap    = I_exc || irq_take || illegal_mret;
        take_mret    = I_mret && !take_trap;
        irq_flag     = 1'b0;
        trap_cause   = CAUSE_W'(CAUSE_ILLEGAL);
        unique case (1'b1)
            I_exc:    trap_cause = I_exc_cause;
            irq_take: begin
                trap_cause = CAUSE_W'(CAUSE_MEI);
                irq_flag   = 1'b1;
            end
            default:  trap_cause = CAUSE_W'(CAUSE_ILLEGAL);
        endcase
        mcause_next              = '0;
        mcause_next[CAUSE_W-1:0] = trap_cause;
        mcause_next[XLEN-1]      = irq_flag;
    end

    // Redirect FSM with registered mux controls
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state  <= RUN;
            O_en   <= 1'b0;
            O_sel  <= 1'b0;
            O_busy <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (take_trap) begin
                        state  <= ENTER;
                        O_en   <= 1'b1;
                        O_sel  <= 1'b0;
                        O_busy <= 1'b1;
                    end else if (take_mret) begin
                        state  <= EXIT;
                        O_en   <= 1'b1;
                        O_sel  <= 1'b1;
                        O_busy <= 1'b1;
                    end
                end
                ENTER, EXIT: begin
                    if (I_ready) begin
                        state  <= RUN;
                        O_en   <= 1'b0;
                        O_sel  <= 1'b0;
                        O_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    O_en   <= 1'b0;
                    O_sel  <= 1'b0;
                    O_busy <= 1'b0;
                end
            endcase
        end
    end

    // CSR capture on RUN->ENTER and restore on RUN->EXIT only
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_mepc   <= '0;
            O_mcause <= '0;
            O_priv   <= PRIV_M;
            O_mie    <= 1'b0;
            mpie     <= 1'b0;
            mpp      <= PRIV_M;
        end else if (state == RUN) begin
            if (take_trap) begin
                O_mepc   <= {I_pc[XLEN-1:2], 2'b00};
                O_mcause <= mcause_next;
                mpie     <= O_mie;
                O_mie    <= 1'b0;
                mpp      <= O_priv;
                O_priv   <= PRIV_M;
            end else if (take_mret) begin
                O_mie    <= mpie;
                mpie     <= 1'b1;
                O_priv   <= mpp;
                mpp      <= PRIV_U;
            end
        end
    end

    assign O_flush = O_en;

endmodule
